ahub_arbiter: RTL and testbench

AHUB_ARBITER -- requirements
Module: ahub_arbiter

---
 rtl/ahub_arbiter_pkg.sv | 51 +++++
 rtl/hub_ram.sv | 27 ++
 rtl/ahub_arbiter.sv | 127 ++++++++++++
 tb/tb_ahub_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahub_arbiter_pkg.sv
// Shared definitions for the hub arbiter: size encodings, limits and
// byte-lane helpers used to steer data between cogs and 32-bit hub words.
package ahub_arbiter_pkg;

  localparam int HUB_MEM_WIDTH_DEF = 15;
  localparam int NUM_COGS_MAX      = 8;
  localparam int SLOT_W            = 3;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_WORD     = 2'b01,
    SZ_LONG     = 2'b10,
    SZ_LONG_ALT = 2'b11
  } hub_sz_e;

  // Lanes touched by an access; low address bits below the access size are ignored.
  function automatic logic [3:0] lane_mask(input hub_sz_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_WORD: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input hub_sz_e sz, input logic [31:0] data);
    case (sz)
      SZ_BYTE: lane_replicate = {4{data[7:0]}};
      SZ_WORD: lane_replicate = {2{data[15:0]}};
      default: lane_replicate = data;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input hub_sz_e sz, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: lane_extract = {24'h0, byte_sel};
      SZ_WORD: lane_extract = {16'h0, half_sel};
      default: lane_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/hub_ram.sv
// Single-port hub memory: 32-bit words, per-byte write enables, registered
// read-first output (a combined read/write returns the old contents).
module hub_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk_in,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_in) begin
    rdata_q <= mem_q[addr_i];
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahub_arbiter.sv
// Round-robin hub arbiter: a free-running slot counter grants one cog per
// cycle; the granted access completes with a one-cycle ack the cycle after.
module ahub_arbiter
  import ahub_arbiter_pkg::*;
#(
  parameter int NUM_COGS      = 2,
  parameter int HUB_MEM_WIDTH = HUB_MEM_WIDTH_DEF
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic [NUM_COGS*HUB_MEM_WIDTH-1:0] hub_addr_i,
  input  logic [NUM_COGS-1:0]               hub_read_i,
  input  logic [NUM_COGS-1:0]               hub_write_i,
  input  logic [NUM_COGS*2-1:0]             hub_sz_i,
  input  logic [NUM_COGS*32-1:0]            hub_data_i,
  output logic [NUM_COGS*32-1:0]            hub_data_o,
  output logic [NUM_COGS-1:0]               hub_ack_o,
  output logic [2:0]                        hub_slot_o
);

  localparam int WORD_AW = HUB_MEM_WIDTH - 2;

  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [NUM_COGS-1:0]      ack_q, ack_d;
  logic                     rd_q, rd_d;
  logic [1:0]               off_q, off_d;
  hub_sz_e                  sz_q, sz_d;
  logic [31:0]              data_q [NUM_COGS];
  logic [31:0]              data_d [NUM_COGS];

  logic [HUB_MEM_WIDTH-1:0] cur_addr;
  logic                     cur_read;
  logic                     cur_write;
  logic                     cur_req;
  hub_sz_e                  cur_sz;
  logic [31:0]              cur_wdata;

  logic [WORD_AW-1:0]       ram_addr;
  logic [3:0]               ram_we;
  logic [31:0]              ram_wdata;
  logic [31:0]              ram_rdata;
  logic [31:0]              rd_word;

  // Request mux: only the slot owner's request reaches the memory port.
  always_comb begin
    cur_addr  = '0;
    cur_read  = 1'b0;
    cur_write = 1'b0;
    cur_sz    = SZ_BYTE;
    cur_wdata = '0;
    for (int c = 0; c < NUM_COGS; c++) begin
      if (slot_q == SLOT_W'(c)) begin
        cur_addr  = hub_addr_i[c*HUB_MEM_WIDTH +: HUB_MEM_WIDTH];
        cur_read  = hub_read_i[c];
        cur_write = hub_write_i[c];
        cur_sz    = hub_sz_e'(hub_sz_i[c*2 +: 2]);
        cur_wdata = hub_data_i[c*32 +: 32];
      end
    end
  end

  always_comb begin
    slot_d = (slot_q == SLOT_W'(NUM_COGS - 1)) ? '0 : slot_q + SLOT_W'(1);
  end

  always_comb begin
    cur_req   = cur_read | cur_write;
    ram_addr  = cur_addr[HUB_MEM_WIDTH-1:2];
    ram_we    = (cur_write && reset_in) ? lane_mask(cur_sz, cur_addr[1:0]) : 4'b0000;
    ram_wdata = lane_replicate(cur_sz, cur_wdata);
    rd_d      = cur_req & cur_read;
    off_d     = cur_addr[1:0];
    sz_d      = cur_sz;
    ack_d     = '0;
    for (int c = 0; c < NUM_COGS; c++) begin
      ack_d[c] = cur_req && (slot_q == SLOT_W'(c));
    end
  end

  hub_ram #(
    .ADDR_W (WORD_AW)
  ) u_hub_ram (
    .clk_in  (clk_in),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Read data is steered straight out in the ack cycle and captured for holding.
  always_comb begin
    rd_word = lane_extract(sz_q, off_q, ram_rdata);
    for (int c = 0; c < NUM_COGS; c++) begin
      data_d[c] = (ack_q[c] && rd_q) ? rd_word : data_q[c];
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      slot_q <= '0;
      ack_q  <= '0;
      rd_q   <= 1'b0;
      off_q  <= '0;
      sz_q   <= SZ_BYTE;
      for (int c = 0; c < NUM_COGS; c++) begin
        data_q[c] <= '0;
      end
    end else begin
      slot_q <= slot_d;
      ack_q  <= ack_d;
      rd_q   <= rd_d;
      off_q  <= off_d;
      sz_q   <= sz_d;
      for (int c = 0; c < NUM_COGS; c++) begin
        data_q[c] <= data_d[c];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_COGS; gi++) begin : g_data_out
    assign hub_data_o[gi*32 +: 32] = data_d[gi];
  end

  assign hub_ack_o  = ack_q;
  assign hub_slot_o = slot_q;

endmodule

// File: tb/tb_ahub_arbiter.sv
// Bench for ahub_arbiter: directed transaction table, corner sequences and
// random traffic checked against a byte-addressed memory model.
module tb_ahub_arbiter;

  localparam int N  = 2;
  localparam int AW = 15;

  logic              clk_in = 1'b0;
  logic              reset_in = 1'b1;
  logic [N*AW-1:0]   hub_addr_i;
  logic [N-1:0]      hub_read_i;
  logic [N-1:0]      hub_write_i;
  logic [N*2-1:0]    hub_sz_i;
  logic [N*32-1:0]   hub_data_i;
  logic [N*32-1:0]   hub_data_o;
  logic [N-1:0]      hub_ack_o;
  logic [2:0]        hub_slot_o;

  logic [AW-1:0]     t_addr [N];
  logic              t_rd   [N];
  logic              t_wr   [N];
  logic [1:0]        t_sz   [N];
  logic [31:0]       t_wd   [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign hub_addr_i[gi*AW +: AW] = t_addr[gi];
    assign hub_read_i[gi]          = t_rd[gi];
    assign hub_write_i[gi]         = t_wr[gi];
    assign hub_sz_i[gi*2 +: 2]     = t_sz[gi];
    assign hub_data_i[gi*32 +: 32] = t_wd[gi];
  end

  ahub_arbiter #(
    .NUM_COGS      (N),
    .HUB_MEM_WIDTH (AW)
  ) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .hub_addr_i  (hub_addr_i),
    .hub_read_i  (hub_read_i),
    .hub_write_i (hub_write_i),
    .hub_sz_i    (hub_sz_i),
    .hub_data_i  (hub_data_i),
    .hub_data_o  (hub_data_o),
    .hub_ack_o   (hub_ack_o),
    .hub_slot_o  (hub_slot_o)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: byte memory, slot as a cycle count modulo N.
  logic [7:0]  bmem [1 << AW];
  int          m_slot;
  logic [N-1:0] m_ack;
  logic [31:0] m_data [N];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  typedef struct {
    int          cog;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic [AW-1:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } txn_t;

  txn_t tbl [14];

  function automatic txn_t mk(int cog, logic rd, logic wr, logic [1:0] sz,
                              logic [AW-1:0] addr, logic [31:0] wd, logic [31:0] exp);
    txn_t t;
    t.cog = cog; t.rd = rd; t.wr = wr; t.sz = sz;
    t.addr = addr; t.wd = wd; t.exp = exp;
    return t;
  endfunction

  function automatic int sz_bytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mem_read(logic [1:0] sz, logic [AW-1:0] a);
    int n = sz_bytes(sz);
    int base = int'(a) & ~(n - 1);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[base + i];
    return v;
  endfunction

  task automatic mem_write(logic [1:0] sz, logic [AW-1:0] a, logic [31:0] d);
    int n = sz_bytes(sz);
    int base = int'(a) & ~(n - 1);
    for (int i = 0; i < n; i++) bmem[base + i] = d[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_slot"}, 32'(hub_slot_o), 32'(m_slot));
    check({tag, "_ack"}, 32'(hub_ack_o), 32'(m_ack));
    for (int c = 0; c < N; c++)
      check($sformatf("%s_data%0d", tag, c), hub_data_o[c*32 +: 32], m_data[c]);
  endtask

  task automatic clear(input int c);
    t_rd[c] = 1'b0;
    t_wr[c] = 1'b0;
  endtask

  // One clock: model the access granted this cycle, then check the next cycle.
  task automatic step();
    int s = m_slot;
    m_ack = '0;
    if (t_rd[s] || t_wr[s]) begin
      m_ack[s] = 1'b1;
      if (t_rd[s]) m_data[s] = mem_read(t_sz[s], t_addr[s]);
      if (t_wr[s]) mem_write(t_sz[s], t_addr[s], t_wd[s]);
    end
    m_slot = (m_slot + 1) % N;
    @(posedge clk_in);
    #1;
    cyc++;
    check_outputs("step");
  endtask

  task automatic do_reset(input int hold);
    for (int c = 0; c < N; c++) clear(c);
    reset_in = 1'b0;
    #1;
    m_slot = 0;
    m_ack  = '0;
    for (int c = 0; c < N; c++) m_data[c] = '0;
    check_outputs("rst_now");
    repeat (hold) @(posedge clk_in);
    #1;
    check_outputs("rst_hold");
    reset_in = 1'b1;
  endtask

  task automatic do_txn(input txn_t t, input string tag);
    bit seen = 1'b0;
    t_addr[t.cog] = t.addr;
    t_rd[t.cog]   = t.rd;
    t_wr[t.cog]   = t.wr;
    t_sz[t.cog]   = t.sz;
    t_wd[t.cog]   = t.wd;
    for (int k = 0; k < N + 2 && !seen; k++) begin
      step();
      if (hub_ack_o[t.cog] === 1'b1) begin
        seen = 1'b1;
        clear(t.cog);
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_ack: got no ack expected ack within %0d cycles", tag, N + 2);
      clear(t.cog);
    end else begin
      check({tag, "_ackslot"}, 32'(hub_slot_o), 32'((t.cog + 1) % N));
      if (t.rd) check({tag, "_rdata"}, hub_data_o[t.cog*32 +: 32], t.exp);
      $display("txn %s cog%0d rd=%0b wr=%0b sz=%0d addr=%h wdata=%h rdata=%h cycle=%0d",
               tag, t.cog, t.rd, t.wr, t.sz, t.addr, t.wd, hub_data_o[t.cog*32 +: 32], cyc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, k;
    bit acked;
    logic [31:0] keep;

    for (int c = 0; c < N; c++) begin
      t_addr[c] = '0; t_rd[c] = 1'b0; t_wr[c] = 1'b0; t_sz[c] = '0; t_wd[c] = '0;
      m_data[c] = '0;
    end
    for (int i = 0; i < (1 << AW); i++) bmem[i] = '0;
    m_ack = '0;
    m_slot = 0;
    #1;
    do_reset(3);

    tbl[0]  = mk(0, 1'b0, 1'b1, 2'b10, 15'h0100, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(1, 1'b1, 1'b0, 2'b10, 15'h0100, 32'h0,        32'hDEADBEEF);
    tbl[2]  = mk(1, 1'b0, 1'b1, 2'b00, 15'h0102, 32'h000000A5, 32'h0);
    tbl[3]  = mk(1, 1'b1, 1'b0, 2'b10, 15'h0100, 32'h0,        32'hDEA5BEEF);
    tbl[4]  = mk(1, 1'b1, 1'b0, 2'b00, 15'h0102, 32'h0,        32'h000000A5);
    tbl[5]  = mk(0, 1'b0, 1'b1, 2'b10, 15'h0200, 32'h55667788, 32'h0);
    tbl[6]  = mk(0, 1'b1, 1'b1, 2'b10, 15'h0200, 32'h11223344, 32'h55667788);
    tbl[7]  = mk(0, 1'b1, 1'b0, 2'b10, 15'h0200, 32'h0,        32'h11223344);
    tbl[8]  = mk(0, 1'b0, 1'b1, 2'b01, 15'h0203, 32'h0000BEEF, 32'h0);
    tbl[9]  = mk(1, 1'b1, 1'b0, 2'b01, 15'h0202, 32'h0,        32'h0000BEEF);
    tbl[10] = mk(0, 1'b1, 1'b0, 2'b10, 15'h0203, 32'h0,        32'hBEEF3344);
    tbl[11] = mk(0, 1'b1, 1'b0, 2'b11, 15'h0200, 32'h0,        32'hBEEF3344);
    tbl[12] = mk(1, 1'b1, 1'b0, 2'b00, 15'h0201, 32'h0,        32'h00000033);
    tbl[13] = mk(1, 1'b1, 1'b0, 2'b01, 15'h0101, 32'h0,        32'h0000BEEF);
    for (int i = 0; i < 14; i++) do_txn(tbl[i], $sformatf("T%0d", i));

    // Both cogs request together starting in slot 0: cog0 first, separate acks.
    k = 0;
    while (hub_slot_o != 3'd0 && k < N + 1) begin step(); k++; end
    for (int c = 0; c < N; c++) begin
      t_addr[c] = 15'h0100; t_sz[c] = 2'b10; t_rd[c] = 1'b1; t_wr[c] = 1'b0;
    end
    a0 = -1; a1 = -1;
    for (int j = 0; j < 2 * N + 2; j++) begin
      step();
      if (hub_ack_o[0] && a0 < 0) begin a0 = j; clear(0); end
      if (hub_ack_o[1] && a1 < 0) begin a1 = j; clear(1); end
    end
    check("both_order", 32'(a0 >= 0 && a1 >= 0 && a0 < a1), 32'd1);
    $display("txn both_req ack0_step=%0d ack1_step=%0d cycle=%0d", a0, a1, cyc);

    // Cog0 pulses a read only during slot 1 and drops it: no access.
    k = 0;
    while (hub_slot_o != 3'd1 && k < N + 1) begin step(); k++; end
    keep = m_data[0];
    t_addr[0] = 15'h0200; t_sz[0] = 2'b10; t_rd[0] = 1'b1; t_wr[0] = 1'b0;
    step();
    clear(0);
    acked = 1'b0;
    repeat (3) begin
      step();
      if (hub_ack_o[0]) acked = 1'b1;
    end
    check("drop_noack", 32'(acked), 32'd0);
    check("drop_hold", hub_data_o[31:0], keep);
    $display("txn drop_req cog0 acked=%0b cycle=%0d", acked, cyc);

    // Reset in the ack cycle of a read cancels ack and data.
    do_txn(mk(1, 1'b1, 1'b0, 2'b10, 15'h0100, 32'h0, 32'hDEA5BEEF), "R_pre");
    do_reset(2);
    // Reset in the ack cycle of a write keeps the committed write.
    do_txn(mk(0, 1'b0, 1'b1, 2'b10, 15'h0300, 32'hCAFEF00D, 32'h0), "W_pre");
    do_reset(1);
    do_txn(mk(1, 1'b1, 1'b0, 2'b10, 15'h0300, 32'h0, 32'hCAFEF00D), "W_post");

    // Random traffic over a prefilled window.
    for (int w = 0; w < 8; w++)
      do_txn(mk(w % N, 1'b0, 1'b1, 2'b10, AW'(15'h0400 + 4 * w), $urandom, 32'h0),
             $sformatf("P%0d", w));
    for (int it = 0; it < 600; it++) begin
      for (int c = 0; c < N; c++) begin
        if (!(t_rd[c] || t_wr[c])) begin
          if ($urandom_range(0, 2) == 0) begin
            int kind = $urandom_range(0, 2);
            t_addr[c] = AW'(15'h0400 + $urandom_range(0, 31));
            t_sz[c]   = 2'($urandom_range(0, 3));
            t_wd[c]   = $urandom;
            t_rd[c]   = (kind != 1);
            t_wr[c]   = (kind != 0);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          clear(c);
        end
      end
      step();
      for (int c = 0; c < N; c++) if (hub_ack_o[c]) clear(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
